// File: rtl/pipe_adder_pkg.sv
// Shared constants and helpers for the pipelined adder/subtractor.
package pipe_adder_pkg;

  localparam int DEF_WIDTH   = 16;
  localparam int DEF_STAGE_W = 4;

  // Operation select carried on the sub input
  typedef enum logic {
    ADD = 1'b0,
    SUB = 1'b1
  } mode_e;

  // Legal geometry: at least one bit per stage and whole slices only
  function automatic bit paramsOk(input int width, input int stageW);
    return (stageW >= 1) && (width >= stageW) && ((width % stageW) == 0);
  endfunction

  // Number of pipeline stages, which is also the latency in cycles
  function automatic int stageCount(input int width, input int stageW);
    return width / stageW;
  endfunction

endpackage

// File: rtl/pipe_adder_slice.sv
// Combinational STAGE_W-bit ripple of full-adder cells, one per bit.
module adder_slice #(
  parameter int STAGE_W = 4
) (
  input  logic [STAGE_W-1:0] a,
  input  logic [STAGE_W-1:0] b,
  input  logic               ci,
  output logic [STAGE_W-1:0] s,
  output logic               co,
  output logic               c_msb_in
);

  logic [STAGE_W:0] carry;

  // Ripple the carry upward through one full-adder cell per bit
  always_comb begin
    carry    = '0;
    s        = '0;
    carry[0] = ci;
    for (int i = 0; i < STAGE_W; i++) begin
      s[i]         = a[i] ^ b[i] ^ carry[i];
      carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
    end
  end

  assign co       = carry[STAGE_W];
  assign c_msb_in = carry[STAGE_W-1];

endmodule

// File: rtl/pipe_adder.sv
// Pipelined adder/subtractor: one STAGE_W-bit slice per stage, carries
// rippled between stages through registers, valid/ready with backpressure.
module pipe_adder
  import pipe_adder_pkg::*;
#(
  parameter int WIDTH   = DEF_WIDTH,
  parameter int STAGE_W = DEF_STAGE_W
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int NSTAGE = stageCount(WIDTH, STAGE_W);

  if (!paramsOk(WIDTH, STAGE_W)) begin : gBadParams
    $error("pipe_adder: WIDTH must be a positive multiple of STAGE_W");
  end

  logic             isSub;
  logic             c0;
  logic             stall;
  logic             advance;
  logic             acceptIn;
  logic             lastValid;
  logic [WIDTH-1:0] opB;

  // Subtraction is A + ~B + ~cin, so only B and the carry-in are conditioned
  assign isSub    = (mode_e'(sub) == SUB);
  assign opB      = isSub ? ~in2 : in2;
  assign c0       = isSub ? ~cin : cin;

  // A held result freezes every stage at once so nothing is lost or duplicated
  assign stall    = lastValid & ~out_ready;
  assign advance  = ~stall;
  assign in_ready = ~stall;
  assign acceptIn = in_valid & in_ready;

  for (genvar k = 0; k < NSTAGE; k++) begin : gStage
    localparam int LO = k * STAGE_W;
    localparam int HI = LO + STAGE_W - 1;

    logic               valid_q;
    logic               carry_q;
    logic [HI:0]        res_q;
    logic [HI:0]        res_d;
    logic               inValid;
    logic               ci;
    logic               co;
    logic [STAGE_W-1:0] aSlice;
    logic [STAGE_W-1:0] bSlice;
    logic [STAGE_W-1:0] sSlice;

    if (k == 0) begin : gFirst
      assign inValid = acceptIn;
      assign aSlice  = in1[HI:LO];
      assign bSlice  = opB[HI:LO];
      assign ci      = c0;
      assign res_d   = sSlice;
    end else begin : gNext
      assign inValid = gStage[k-1].valid_q;
      assign aSlice  = gStage[k-1].gSkew.opA_q[HI:LO];
      assign bSlice  = gStage[k-1].gSkew.opB_q[HI:LO];
      assign ci      = gStage[k-1].carry_q;
      assign res_d   = {sSlice, gStage[k-1].res_q};
    end

    if (k < NSTAGE - 1) begin : gSkew
      logic [WIDTH-1:HI+1] opA_q;
      logic [WIDTH-1:HI+1] opB_q;
      logic [WIDTH-1:HI+1] opA_d;
      logic [WIDTH-1:HI+1] opB_d;

      if (k == 0) begin : gSrc
        assign opA_d = in1[WIDTH-1:HI+1];
        assign opB_d = opB[WIDTH-1:HI+1];
      end else begin : gSrc
        assign opA_d = gStage[k-1].gSkew.opA_q[WIDTH-1:HI+1];
        assign opB_d = gStage[k-1].gSkew.opB_q[WIDTH-1:HI+1];
      end

      // Carry the not-yet-added upper operand slices one stage further
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          opA_q <= '0;
          opB_q <= '0;
        end else if (advance && inValid) begin
          opA_q <= opA_d;
          opB_q <= opB_d;
        end
      end
    end

    if (k == NSTAGE - 1) begin : gLast
      logic cMsbIn;
      logic ovf_q;

      adder_slice #(.STAGE_W(STAGE_W)) uSlice (
        .a        (aSlice),
        .b        (bSlice),
        .ci       (ci),
        .s        (sSlice),
        .co       (co),
        .c_msb_in (cMsbIn)
      );

      // Signed overflow compares the carries into and out of the result MSB
      always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
          ovf_q <= 1'b0;
        end else if (advance && inValid) begin
          ovf_q <= cMsbIn ^ co;
        end
      end
    end else begin : gMid
      logic cMsbUnused;

      adder_slice #(.STAGE_W(STAGE_W)) uSlice (
        .a        (aSlice),
        .b        (bSlice),
        .ci       (ci),
        .s        (sSlice),
        .co       (co),
        .c_msb_in (cMsbUnused)
      );
    end

    // Each stage valid follows its predecessor so bubbles travel intact
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        valid_q <= 1'b0;
      end else if (advance) begin
        valid_q <= inValid;
      end
    end

    // Slice result and carry load only for a real operation, keeping outputs steady
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        res_q   <= '0;
        carry_q <= 1'b0;
      end else if (advance && inValid) begin
        res_q   <= res_d;
        carry_q <= co;
      end
    end
  end

  assign lastValid = gStage[NSTAGE-1].valid_q;
  assign out_valid = lastValid;
  assign sum       = gStage[NSTAGE-1].res_q;
  assign cout      = gStage[NSTAGE-1].carry_q;
  assign ovf       = gStage[NSTAGE-1].gLast.ovf_q;

endmodule

// File: tb/tb_pipe_adder.sv
// Directed bench for pipe_adder with WIDTH=16, STAGE_W=4 (latency 4).
module tb_pipe_adder;

  logic        sys_clk = 1'b0;
  logic        sys_rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] in1;
  logic [15:0] in2;
  logic        cin;
  logic        sub;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int passCount  = 0;
  int checkCount = 0;
  int failCount  = 0;

  pipe_adder #(.WIDTH(16), .STAGE_W(4)) dut (
    .sys_clk   (sys_clk),
    .sys_rst_n (sys_rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in1       (in1),
    .in2       (in2),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf)
  );

  always #5 sys_clk = ~sys_clk;

  // Reference result packed as {cout, ovf, sum}
  function automatic logic [17:0] refModel(input logic [15:0] a, input logic [15:0] b,
                                           input logic c, input logic s);
    logic [15:0] bEff;
    logic        cEff;
    logic [16:0] full;
    logic [15:0] low;
    bEff = s ? ~b : b;
    cEff = s ? ~c : c;
    full = {1'b0, a} + {1'b0, bEff} + {16'd0, cEff};
    low  = {1'b0, a[14:0]} + {1'b0, bEff[14:0]} + {15'd0, cEff};
    return {full[16], low[15] ^ full[16], full[15:0]};
  endfunction

  task automatic applyStimulus(input logic v, input logic [15:0] a, input logic [15:0] b,
                               input logic c, input logic s);
    in_valid = v;
    in1      = a;
    in2      = b;
    cin      = c;
    sub      = s;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checkCount++;
    assert (obs === expv) passCount++;
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // One isolated operation: check latency, result, and that it drains
  task automatic runSingle(input string tag, input logic [15:0] a, input logic [15:0] b,
                           input logic c, input logic s, input logic [17:0] expv);
    int lat;
    applyStimulus(1'b1, a, b, c, s);
    @(negedge sys_clk);
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 12) begin
      @(negedge sys_clk);
      lat++;
    end
    checkOutput({tag, "_latency"}, lat, 4);
    checkOutput({tag, "_result"}, {14'd0, cout, ovf, sum}, {14'd0, expv});
    @(negedge sys_clk);
    checkOutput({tag, "_drained"}, {31'd0, out_valid}, 0);
  endtask

  logic [15:0] opA [8];
  logic [15:0] opB [8];
  logic        opC [8];
  logic        opS [8];
  logic [17:0] expR [8];

  initial begin
    int rcv;
    int firstCyc;
    int lastCyc;
    int gaps;
    int srcIdx;
    int staleCount;
    logic accepted;
    logic expReady;
    logic [17:0] heldVal;

    sys_rst_n = 1'b0;
    out_ready = 1'b1;
    applyStimulus(1'b0, 16'h0, 16'h0, 1'b0, 1'b0);
    $display("[TB] reset state");
    @(negedge sys_clk);
    @(negedge sys_clk);
    checkOutput("rst_out_valid", {31'd0, out_valid}, 0);
    checkOutput("rst_result", {14'd0, cout, ovf, sum}, 0);
    sys_rst_n = 1'b1;
    #1;
    checkOutput("rst_in_ready", {31'd0, in_ready}, 1);
    @(negedge sys_clk);

    $display("[TB] directed vectors");
    runSingle("add_wrap",  16'hFFFF, 16'h0001, 1'b0, 1'b0, {1'b1, 1'b0, 16'h0000});
    runSingle("add_ovf",   16'h7FFF, 16'h0001, 1'b0, 1'b0, {1'b0, 1'b1, 16'h8000});
    runSingle("add_chain", 16'h00FF, 16'h0000, 1'b1, 1'b0, {1'b0, 1'b0, 16'h0100});
    runSingle("sub_neg",   16'h0005, 16'h0007, 1'b0, 1'b1, {1'b0, 1'b0, 16'hFFFE});
    runSingle("sub_ovf",   16'h8000, 16'h0001, 1'b0, 1'b1, {1'b1, 1'b1, 16'h7FFF});

    $display("[TB] streaming");
    for (int i = 0; i < 8; i++) begin
      opA[i]  = 16'($urandom);
      opB[i]  = 16'($urandom);
      opC[i]  = 1'($urandom);
      opS[i]  = 1'($urandom);
      expR[i] = refModel(opA[i], opB[i], opC[i], opS[i]);
    end
    rcv = 0; firstCyc = -1; lastCyc = -1; gaps = 0;
    for (int cyc = 0; cyc < 16; cyc++) begin
      if (cyc < 8) applyStimulus(1'b1, opA[cyc], opB[cyc], opC[cyc], opS[cyc]);
      else in_valid = 1'b0;
      @(negedge sys_clk);
      if (out_valid) begin
        if (firstCyc < 0) firstCyc = cyc;
        else if (cyc != lastCyc + 1) gaps++;
        lastCyc = cyc;
        if (rcv < 8) checkOutput("stream_result", {14'd0, cout, ovf, sum}, {14'd0, expR[rcv]});
        rcv++;
      end
    end
    checkOutput("stream_first", firstCyc, 3);
    checkOutput("stream_count", rcv, 8);
    checkOutput("stream_gaps", gaps, 0);

    $display("[TB] backpressure");
    for (int i = 0; i < 8; i++) begin
      opA[i]  = 16'($urandom);
      opB[i]  = 16'($urandom);
      opC[i]  = 1'($urandom);
      opS[i]  = 1'($urandom);
      expR[i] = refModel(opA[i], opB[i], opC[i], opS[i]);
    end
    srcIdx = 0; rcv = 0; heldVal = '0;
    for (int cyc = 0; cyc < 30; cyc++) begin
      out_ready = !(cyc >= 6 && cyc <= 8);
      if (srcIdx < 8) applyStimulus(1'b1, opA[srcIdx], opB[srcIdx], opC[srcIdx], opS[srcIdx]);
      else in_valid = 1'b0;
      #1;
      expReady = !(cyc >= 6 && cyc <= 8);
      if (cyc < 14) checkOutput("bp_in_ready", {31'd0, in_ready}, {31'd0, expReady});
      if (cyc == 6) heldVal = {cout, ovf, sum};
      if (cyc == 7 || cyc == 8) checkOutput("bp_held", {14'd0, cout, ovf, sum}, {14'd0, heldVal});
      if (out_valid && out_ready) begin
        if (rcv < 8) checkOutput("bp_result", {14'd0, cout, ovf, sum}, {14'd0, expR[rcv]});
        rcv++;
      end
      accepted = in_valid && in_ready;
      @(negedge sys_clk);
      if (accepted) srcIdx++;
    end
    checkOutput("bp_count", rcv, 8);
    checkOutput("bp_drained", {31'd0, out_valid}, 0);

    $display("[TB] reset mid-stream");
    runSingle("pre_rst", 16'h1234, 16'h1111, 1'b0, 1'b0, {1'b0, 1'b0, 16'h2345});
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b1, 16'h0100 + 16'(i), 16'h0203, 1'b0, 1'b0);
      @(negedge sys_clk);
    end
    in_valid = 1'b0;
    #3;
    sys_rst_n = 1'b0;
    #1;
    checkOutput("midrst_out_valid", {31'd0, out_valid}, 0);
    checkOutput("midrst_result", {14'd0, cout, ovf, sum}, 0);
    @(negedge sys_clk);
    sys_rst_n = 1'b1;
    staleCount = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(negedge sys_clk);
      if (out_valid) staleCount++;
    end
    checkOutput("midrst_stale", staleCount, 0);
    runSingle("post_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, {1'b0, 1'b0, 16'h1000});

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

endmodule

// File: doc/pipe_adder.md
Name: pipe_adder

Overview:
Parametrised, pipelined N-bit adder/subtractor with carry-in, carry-out and signed-overflow flags. The operand is split into STAGE_W-bit slices, one slice per pipeline stage, and the carry ripples between stages through registers. The block accepts one operation per clock under a valid/ready handshake, with backpressure from the consumer. It is the multi-bit, clocked successor of the team's single-bit full adder and serves as the arithmetic primitive for counters, accumulators and ALU datapaths.

Parameters:
WIDTH, 16, operand/result width in bits; must be a multiple of STAGE_W.
STAGE_W, 4, bits added per pipeline stage; NSTAGE = WIDTH/STAGE_W is the latency in cycles.

Ports:
sys_clk  input  1  system clock, all logic on rising edge
sys_rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operation present on in1/in2/cin/sub
in_ready  output  1  block can accept an operation this cycle
in1  input  WIDTH  operand A, unsigned or two's complement
in2  input  WIDTH  operand B
cin  input  1  carry-in (add) / borrow-in (sub)
sub  input  1  0: A+B+cin; 1: A-B-cin
out_valid  output  1  result present
out_ready  input  1  consumer accepts result
sum  output  WIDTH  result, modulo 2^WIDTH
cout  output  1  raw carry out of MSB (sub mode: 1 = no borrow)
ovf  output  1  signed overflow = carry into MSB XOR carry out of MSB

Behaviour:
- Clock and reset: single clock sys_clk; reset sys_rst_n is asynchronous, active-low.
- Reset: every valid bit, carry register and data register is cleared to 0. So out_valid=0, sum=0, cout=0, ovf=0, and in_ready=1 once reset is released.
- Operand conditioning, done at stage 0 input:
  - B' = sub ? ~in2 : in2.
  - Effective carry-in c0 = sub ? ~cin : cin.
  - Sub mode therefore computes A + ~B + ~cin = A - B - cin.
- Stage k (0..NSTAGE-1):
  - Adds slice k of A and B' plus the carry registered by stage k-1 (c0 for stage 0).
  - Registers the slice sum and the carry-out.
- Skew and deskew:
  - Higher slices of A/B' travel through skew registers so they reach stage k exactly k cycles after capture.
  - Lower result slices travel through deskew registers so all slices emerge together.
- Latency: a transfer accepted in cycle t (in_valid & in_ready) gives out_valid=1 with the complete result in cycle t+NSTAGE, provided no stall occurs.
- Throughput: one operation per cycle. Each stage carries its own valid bit; bubbles are preserved.
- Backpressure:
  - stall = out_valid & ~out_ready; in_ready = ~stall.
  - While stall=1, the whole pipeline holds: no register advances and sum/cout/ovf stay stable.
  - in_valid while in_ready=0 is ignored; the source holds it.
- Output transfer occurs when out_valid & out_ready. On that same cycle a new input can be accepted.
- Flags are computed in the final stage from its MSB carry-in and carry-out. They are valid only while out_valid=1 and hold their last value otherwise.
- A register may load its data only when its stage valid is 1. Data registers may retain old data under bubbles, but outputs must not glitch while out_valid=1 and stall=1.
- Reset mid-operation: all in-flight operations are discarded immediately, with no partial output.
- Wrap-around:
  - Overflow of the unsigned result is reported only through cout; sum wraps modulo 2^WIDTH.
  - NSTAGE=1 degenerates to a single registered adder with latency 1.

Decomposition:
- Shared package/header holds:
  - Localparam NSTAGE = WIDTH/STAGE_W.
  - Elaboration check that WIDTH % STAGE_W == 0 and STAGE_W >= 1.
  - Mode constants ADD=0, SUB=1.
- One natural sub-module: adder_slice. It is a combinational STAGE_W-bit ripple of full-adder cells with ports a, b, ci, s, co and c_msb_in (carry into its top bit, used for ovf).
- pipe_adder instantiates NSTAGE adder_slice instances plus the skew, deskew and valid registers.

Test Plan:
All cases use WIDTH=16, STAGE_W=4 (latency 4).
- Add wrap: in1=0xFFFF, in2=0x0001, cin=0, sub=0 -> 4 cycles later sum=0x0000, cout=1, ovf=0.
- Signed overflow plus carry chain: in1=0x7FFF, in2=0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1. Then in1=0x00FF, in2=0x0000, cin=1 -> sum=0x0100, cout=0, ovf=0.
- Subtract: in1=0x0005, in2=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0, ovf=0. Then in1=0x8000, in2=0x0001, sub=1 -> sum=0x7FFF, cout=1, ovf=1.
- Streaming: 8 back-to-back random operations with out_ready=1 -> 8 consecutive out_valid cycles, starting 4 cycles after the first accept, in order, all matching the reference model.
- Backpressure: drop out_ready for 3 cycles while the pipeline is full -> in_ready=0 for exactly those cycles, sum/cout/ovf held stable, no operation lost or duplicated after release.
- Reset mid-stream: assert sys_rst_n=0 asynchronously with 3 operations in flight -> out_valid=0 and sum=0 immediately. After release, no stale results appear and a new operation returns after 4 cycles.
